// File: rtl/mdu_seq_if.sv
// Handshake and data bundle between the EX stage and the multiply/divide
// sequencer. The CPU side (or a testbench) drives through master; the
// sequencer connects through slave.
interface mdu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             flush_i;
  logic             stall_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;

  modport master (
    output start_i, op_i, src1_i, src2_i, flush_i,
    input  stall_o, busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, src1_i, src2_i, flush_i,
    output stall_o, busy_o, done_o, result_o
  );
endinterface

// File: rtl/mdu_seq.sv
// mdu_seq: iterative unsigned multiply/divide sequencer, one bit per cycle.
//   op 00 MUL (low word), 01 MULHU (high word), 10 DIVU, 11 REMU.
// The pipeline is stalled while an operation is in flight. done_o pulses for
// one cycle with result_o valid, and flush_i aborts without a done pulse.
// Optional build macro MDU_EARLY_OUT_EN: trivial operands (zero multiply
// operand, zero divisor, dividend below divisor) skip the iterations.
//
//   state  | meaning
//   IDLE   | waiting for start_i
//   BUSY   | iterating, WIDTH cycles
//   DONE   | done_o high, result_o just updated; start_i chains the next op
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic      clk_i,
  input  logic      rst_i,
  mdu_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_opnd2;   // multiplicand or divisor
  logic [2*WIDTH-1:0] r_prod;    // {partial high, remaining multiplier}
  logic [WIDTH:0]     r_rem;     // partial remainder, one guard bit
  logic [WIDTH-1:0]   r_quo;     // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0]   r_result;
  logic               r_busy;
  logic               r_done;

  logic               w_launch;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_rem_diff;
  logic               w_fits;
  logic [WIDTH:0]     w_rem_nxt;
  logic [WIDTH-1:0]   w_quo_nxt;
  logic [WIDTH-1:0]   w_sel;
  logic               w_early;
  logic [WIDTH-1:0]   w_early_res;

  // Flush beats start everywhere; a new op may launch from IDLE or DONE.
  assign w_launch = bus.start_i & ~bus.flush_i & (r_state != S_BUSY);

  // One shift-and-add step and one restoring-divide step, plus the word
  // the current op would deliver if this is the final iteration.
  always_comb begin
    w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} +
                 (r_prod[0] ? {1'b0, r_opnd2} : {(WIDTH+1){1'b0}});
    w_prod_nxt = {w_mul_sum, r_prod[WIDTH-1:1]};
    w_rem_sh   = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    w_rem_diff = w_rem_sh - {1'b0, r_opnd2};
    w_fits     = ~w_rem_diff[WIDTH];
    w_rem_nxt  = w_fits ? w_rem_diff : w_rem_sh;
    w_quo_nxt  = {r_quo[WIDTH-2:0], w_fits};
    case (r_op)
      2'b00:   w_sel = w_prod_nxt[WIDTH-1:0];
      2'b01:   w_sel = w_prod_nxt[2*WIDTH-1:WIDTH];
      2'b10:   w_sel = w_quo_nxt;
      default: w_sel = w_rem_nxt[WIDTH-1:0];
    endcase
  end

`ifdef MDU_EARLY_OUT_EN
  // Trivial operand detection; the values match what the full iteration
  // would produce, so both builds return identical results.
  always_comb begin
    w_early     = 1'b0;
    w_early_res = '0;
    if (!bus.op_i[1]) begin
      w_early = (bus.src1_i == '0) || (bus.src2_i == '0);
    end else begin
      w_early = (bus.src2_i == '0) || (bus.src1_i < bus.src2_i);
      if (bus.op_i[0])
        w_early_res = bus.src1_i;
      else if (bus.src2_i == '0)
        w_early_res = '1;
    end
  end
`else
  assign w_early     = 1'b0;
  assign w_early_res = '0;
`endif

  // Sequencer FSM, datapath registers and registered status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= 2'b00;
      r_opnd2  <= '0;
      r_prod   <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (bus.flush_i) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (w_launch) begin
      r_op    <= bus.op_i;
      r_opnd2 <= bus.src2_i;
      r_prod  <= {{WIDTH{1'b0}}, bus.src1_i};
      r_rem   <= '0;
      r_quo   <= bus.src1_i;
      if (w_early) begin
        r_state  <= S_DONE;
        r_cnt    <= '0;
        r_busy   <= 1'b0;
        r_done   <= 1'b1;
        r_result <= w_early_res;
      end else begin
        r_state <= S_BUSY;
        r_cnt   <= CW'(WIDTH);
        r_busy  <= 1'b1;
        r_done  <= 1'b0;
      end
    end else begin
      case (r_state)
        S_BUSY: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_op[1]) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
          end else begin
            r_prod <= w_prod_nxt;
          end
          if (r_cnt == CW'(1)) begin
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= w_sel;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Stall covers the launching IDLE cycle and all of BUSY; it is low in DONE
  // so the pipeline moves on in the cycle that captures the result.
  assign bus.stall_o  = ((r_state == S_IDLE) & bus.start_i & ~bus.flush_i) |
                        (r_state == S_BUSY);
  assign bus.busy_o   = r_busy;
  assign bus.done_o   = r_done;
  assign bus.result_o = r_result;
endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed cases plus random operations
// compared against plain-arithmetic reference results and expected timing.
module tb_mdu_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic [W-1:0] last_res = '0;

  mdu_seq_if #(.WIDTH(W)) bus ();

  mdu_seq #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      2'd0:    return p[W-1:0];
      2'd1:    return p[2*W-1:W];
      2'd2:    return (b == 0) ? {W{1'b1}} : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MDU_EARLY_OUT_EN
    if (op < 2 && (a == 0 || b == 0)) return 1;
    if (op >= 2 && (b == 0 || a < b)) return 1;
`endif
    return W + 1;
  endfunction

  // Launch one op. With b2b the caller is in a DONE cycle and start is
  // raised there; otherwise one idle cycle is inserted first. Returns in
  // the done cycle, #1 after the falling edge.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit b2b, input string tag);
    logic [W-1:0] exp_res;
    int exp_lat, lat, stalls;
    exp_res = ref_result(op, a, b);
    exp_lat = ref_latency(op, a, b);
    if (!b2b) begin
      @(negedge clk);
      #1;
    end
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.src1_i  = a;
    bus.src2_i  = b;
    #1;
    stalls = bus.stall_o ? 1 : 0;
    lat = 0;
    for (int k = 1; k <= W + 8 && lat == 0; k++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      bus.src1_i  = $urandom;
      bus.src2_i  = $urandom;
      #1;
      if (bus.stall_o) stalls++;
      if (bus.done_o) lat = k;
    end
    check({tag, " latency"}, W'(lat), W'(exp_lat));
    check({tag, " result"}, bus.result_o, exp_res);
    check({tag, " stall cycles"}, W'(stalls), W'(b2b ? exp_lat - 1 : exp_lat));
    last_res = exp_res;
  endtask

  initial begin
    logic [1:0] op;
    logic [W-1:0] a, b;
    bit seen;
    bus.start_i = 1'b0;
    bus.op_i    = 2'b00;
    bus.src1_i  = '0;
    bus.src2_i  = '0;
    bus.flush_i = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("reset busy", W'(bus.busy_o), W'(0));
    check("reset done", W'(bus.done_o), W'(0));
    check("reset stall", W'(bus.stall_o), W'(0));
    check("reset result", bus.result_o, '0);
    rst = 1'b0;

    // Directed cases
    run_op(2'd0, 32'd7, 32'd6, 1'b0, "MUL 7x6");
    run_op(2'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, "MULHU ffffffff x2");
    run_op(2'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, "MUL ffffffff x2");
    run_op(2'd2, 32'd100, 32'd7, 1'b0, "DIVU 100/7");
    run_op(2'd3, 32'd100, 32'd7, 1'b1, "REMU 100/7 b2b");
    run_op(2'd2, 32'h1234, 32'd0, 1'b0, "DIVU by 0");
    run_op(2'd3, 32'h1234, 32'd0, 1'b1, "REMU by 0 b2b");
    run_op(2'd2, 32'd5, 32'd9, 1'b0, "DIVU small");
    run_op(2'd1, 32'd0, 32'h8000_0000, 1'b0, "MULHU zero");

    // Flush has priority over start in IDLE
    @(negedge clk);
    bus.start_i = 1'b1; bus.flush_i = 1'b1; bus.op_i = 2'd0;
    bus.src1_i = 32'd9; bus.src2_i = 32'd9;
    #1;
    check("flush idle stall", W'(bus.stall_o), W'(0));
    @(negedge clk);
    bus.start_i = 1'b0; bus.flush_i = 1'b0;
    #1;
    check("flush idle busy", W'(bus.busy_o), W'(0));

    // Flush at cycle 10 of a DIVU
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 2'd2; bus.src1_i = 32'd1000; bus.src2_i = 32'd3;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    check("pre-flush busy", W'(bus.busy_o), W'(1));
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    #1;
    check("flush busy", W'(bus.busy_o), W'(0));
    check("flush stall", W'(bus.stall_o), W'(0));
    seen = 1'b0;
    for (int k = 0; k < W + 8; k++) begin
      @(negedge clk);
      #1;
      if (bus.done_o) seen = 1'b1;
    end
    check("flush no done", W'(seen), W'(0));
    check("flush result kept", bus.result_o, last_res);
    run_op(2'd0, 32'd3, 32'd5, 1'b0, "MUL 3x5 after flush");

    // Asynchronous reset mid-MUL
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 2'd0; bus.src1_i = 32'd123; bus.src2_i = 32'd456;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (14) @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async rst busy", W'(bus.busy_o), W'(0));
    check("async rst stall", W'(bus.stall_o), W'(0));
    check("async rst result", bus.result_o, '0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < W + 8; k++) begin
      @(negedge clk);
      #1;
      if (bus.done_o) seen = 1'b1;
    end
    check("async rst no done", W'(seen), W'(0));

    // Random operations, mixing idle gaps and back-to-back launches
    run_op(2'd0, 32'd1, 32'd1, 1'b0, "rand warmup");
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: a = '0;
        2: b = W'($urandom_range(1, 255));
        3: a = W'($urandom_range(0, 1000));
        default: ;
      endcase
      run_op(op, a, b, bit'($urandom_range(0, 1)), $sformatf("rand%0d op%0d", i, op));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
